// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per clock.
// Optional signed-overflow flag enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             borrow_out
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             br_q;
  logic [CntW-1:0]  cnt_q;
  logic             bit_d, bit_bout;
  logic [WIDTH-1:0] res_next;

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are shifted out of a_q/b_q, so keep a copy for the flag.
  logic a_msb_q, b_msb_q;
`endif

  full_subtractor u_cell (
    .x   (a_q[0]),
    .y   (b_q[0]),
    .bin (br_q),
    .d   (bit_d),
    .bout(bit_bout)
  );

  assign res_next = {bit_d, res_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      br_q       <= 1'b0;
      cnt_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      ovf        <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state_q <= RUN;
            busy    <= 1'b1;
            a_q     <= a;
            b_q     <= b;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
`endif
          end else begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= res_next;
          br_q  <= bit_bout;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_q    <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            diff       <= res_next;
            borrow_out <= bit_bout;
`ifdef SERIAL_SUB_OVF_EN
            // bit_d is the result MSB on the final step.
            ovf        <= (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: an 8-bit instance for directed vectors
// and a 4-bit instance for the full operand sweep.
module tb_serial_subtractor;

  typedef struct packed {
    logic [7:0] d;
    logic       br;
    logic       ov;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0, start4 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy8, done8, borrow8, busy4, done4, borrow4;
  logic [7:0] diff8;
  logic [3:0] diff4;
  logic       ovf8, ovf4;

  int checks = 0;
  int errors = 0;
  exp_t q8[$];
  exp_t q4[$];

  always #5 clk = ~clk;

`ifndef SERIAL_SUB_OVF_EN
  assign ovf8 = 1'b0;
  assign ovf4 = 1'b0;
`endif

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .start     (start8),
    .a         (a8),
    .b         (b8),
    .busy      (busy8),
    .done      (done8),
    .diff      (diff8),
`ifdef SERIAL_SUB_OVF_EN
    .ovf       (ovf8),
`endif
    .borrow_out(borrow8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .start     (start4),
    .a         (a4),
    .b         (b4),
    .busy      (busy4),
    .done      (done4),
    .diff      (diff4),
`ifdef SERIAL_SUB_OVF_EN
    .ovf       (ovf4),
`endif
    .borrow_out(borrow4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Result monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (busy8 && done8) begin
      errors++;
      $display("FAIL dut8_busy_done_overlap: got busy=1 done=1, expected exclusive");
    end
    if (done8) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL dut8_unexpected_done: got done with diff=%h, expected no done", diff8);
      end else begin
        e = q8.pop_front();
`ifdef SERIAL_SUB_OVF_EN
        if (diff8 !== e.d || borrow8 !== e.br || ovf8 !== e.ov) begin
`else
        if (diff8 !== e.d || borrow8 !== e.br) begin
`endif
          errors++;
          $display("FAIL dut8_result: got diff=%h borrow=%b ovf=%b, expected diff=%h borrow=%b ovf=%b",
                   diff8, borrow8, ovf8, e.d, e.br, e.ov);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (busy4 && done4) begin
      errors++;
      $display("FAIL dut4_busy_done_overlap: got busy=1 done=1, expected exclusive");
    end
    if (done4) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL dut4_unexpected_done: got done with diff=%h, expected no done", diff4);
      end else begin
        e = q4.pop_front();
`ifdef SERIAL_SUB_OVF_EN
        if (diff4 !== e.d[3:0] || borrow4 !== e.br || ovf4 !== e.ov) begin
`else
        if (diff4 !== e.d[3:0] || borrow4 !== e.br) begin
`endif
          errors++;
          $display("FAIL dut4_result a=%h b=%h: got diff=%h borrow=%b ovf=%b, expected diff=%h borrow=%b ovf=%b",
                   dut4.a, dut4.b, diff4, borrow4, ovf4, e.d[3:0], e.br, e.ov);
        end
      end
    end
  end

  // Issue one 8-bit operation; operands are scrambled after acceptance.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                     input logic [7:0] ed, input logic eb, input logic eo);
    int lat = 0;
    int nbusy = 0;
    logic [7:0] held;
    logic stable = 1'b1;
    q8.push_back(exp_t'{ed, eb, eo});
    @(posedge clk); #1;
    start8 = 1'b1; a8 = av; b8 = bv;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~av; b8 = ~bv;
    held = diff8;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (busy8) nbusy++;
      if (busy8 && diff8 !== held) stable = 1'b0;
      if (done8) begin
        lat = i;
        break;
      end
    end
    check("op8_done_latency", lat, 9);
    check("op8_busy_cycles", nbusy, 8);
    check("op8_diff_held_during_run", stable, 1);
  endtask

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", busy8, 0);
    check("reset_done", done8, 0);
    check("reset_diff", diff8, 0);
    check("reset_borrow", borrow8, 0);
    check("reset_ovf", ovf8, 0);

    op8(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    op8(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    op8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    op8(8'h7F, 8'h7F, 8'h00, 1'b0, 1'b0);
    op8(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);
    op8(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);
    op8(8'h00, 8'h80, 8'h80, 1'b1, 1'b1);

    // Back-to-back: start held high with new operands during the first run.
    q8.push_back(exp_t'{8'h0F, 1'b0, 1'b0});
    q8.push_back(exp_t'{8'hF0, 1'b1, 1'b0});
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
    @(posedge clk); #1;
    a8 = 8'h20; b8 = 8'h30;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done8) begin lat = i; break; end
    end
    check("b2b_first_latency", lat, 9);
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done8) begin lat = i; break; end
    end
    check("b2b_second_spacing", lat, 9);

    // Reset sampled on the 4th RUN edge aborts the operation.
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'h44; b8 = 8'h11;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrun_rst_busy", busy8, 0);
    check("midrun_rst_done", done8, 0);
    check("midrun_rst_diff", diff8, 0);
    check("midrun_rst_borrow", borrow8, 0);
    check("midrun_rst_ovf", ovf8, 0);
    repeat (12) @(negedge clk);

    // Reset wins over start at the same edge.
    @(posedge clk); #1;
    rst = 1'b1; start8 = 1'b1; a8 = 8'h09; b8 = 8'h01;
    @(posedge clk); #1;
    rst = 1'b0; start8 = 1'b0;
    @(negedge clk);
    check("rst_over_start_busy", busy8, 0);
    repeat (12) @(negedge clk);

    op8(8'h44, 8'h11, 8'h33, 1'b0, 1'b0);

    // Full 4-bit operand sweep.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        logic [3:0] av, bv, dv;
        av = 4'(i);
        bv = 4'(j);
        dv = av - bv;
        q4.push_back(exp_t'{{4'h0, dv}, (i < j), (av[3] != bv[3]) && (dv[3] != av[3])});
        @(posedge clk); #1;
        start4 = 1'b1; a4 = av; b4 = bv;
        @(posedge clk); #1;
        start4 = 1'b0;
        for (int k = 0; k < 12; k++) begin
          @(negedge clk);
          if (done4) break;
        end
      end
    end

    repeat (4) @(negedge clk);
    check("q8_drained", q8.size(), 0);
    check("q4_drained", q4.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request a new subtraction; sampled only when the block is idle or done.
REQ-005 SHALL have ports: a  input  WIDTH  minuend, and b  input  WIDTH  subtrahend, both captured on the accepting edge only.
REQ-006 SHALL have port: busy  output  1  high while bit-steps are in progress.
REQ-007 SHALL have port: done  output  1  one-cycle pulse; result valid.
REQ-008 SHALL have port: diff  output  WIDTH  a minus b modulo 2^WIDTH.
REQ-009 SHALL have port: borrow_out  output  1  final borrow, high when a < b (unsigned).
REQ-010 SHALL have port: ovf  output  1  signed overflow flag, present only when SERIAL_SUB_OVF_EN is defined.

Function
REQ-011 SHALL implement states IDLE, RUN, DONE.
REQ-012 IDLE: start=1 at an edge -> capture a, b; clear internal borrow and bit counter; go to RUN.
REQ-013 RUN: each edge processes one bit, LSB first: d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~a0 & br) | (b0 & br); operand shift registers shift right; d shifts into the result register at MSB.
REQ-014 RUN SHALL last exactly WIDTH edges; counter counts 0..WIDTH-1; the edge with counter = WIDTH-1 loads diff and borrow_out from the completed result and moves to DONE.
REQ-015 Latency: start accepted at edge 0 -> done high during the cycle between edges WIDTH and WIDTH+1.
REQ-016 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; never both.
REQ-017 DONE lasts one cycle; start=1 in DONE is accepted like in IDLE (back-to-back, no dead cycle); otherwise go to IDLE.
REQ-018 start during RUN SHALL be ignored; a and b changes during RUN SHALL not affect the result.
REQ-019 diff and borrow_out SHALL hold their last values until the next DONE entry; they SHALL not change during RUN.
REQ-020 Arithmetic is modulo 2^WIDTH; a = b yields diff = 0, borrow_out = 0.

Reset
REQ-021 rst=1 at any edge, including mid-RUN, SHALL force IDLE, and SHALL clear busy, done, diff, borrow_out, ovf, the counter, the internal borrow and the shift registers to 0.
REQ-022 rst SHALL take priority over start at the same edge; no partial result SHALL surface after reset.

Configuration
REQ-023 Macro SERIAL_SUB_OVF_EN defined: ovf is a port, loaded at DONE entry as (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operands, and held like diff.
REQ-024 Macro undefined: no ovf port and no associated logic; all other behaviour is identical.

Structure
REQ-025 Shared package serial_sub_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default-width constant.
REQ-026 The one-bit cell SHALL be a sub-module full_subtractor (inputs x, y, bin; outputs d, bout; combinational), instantiated once in the datapath.

Verification
REQ-027 WIDTH=8, a=5, b=3, start pulse -> done 9 edges later, diff=2, borrow_out=0, busy high for 8 cycles.
REQ-028 a=3, b=5 -> diff=0xFE, borrow_out=1; with macro: a=0x80, b=0x01 -> diff=0x7F, ovf=1; a=0x7F, b=0x7F -> diff=0, ovf=0.
REQ-029 start held high with new a/b during RUN -> first result unaffected, second operation begins only at the DONE edge (back-to-back), second done exactly 9 edges after the first.
REQ-030 rst asserted at the 4th RUN edge -> next cycle IDLE with all outputs 0; fresh start then completes normally.
REQ-031 Exhaustive sweep at WIDTH=4 of all 256 a/b pairs -> diff = (a-b) mod 16 and borrow_out = (a<b) for each pair.
